// File: rtl/pe_link_pkg.sv
// rtl/pe_link_pkg.sv - shared east-link word layout for PE link logic
package pe_link_pkg;

  localparam int LINK_WIDTH     = 132;
  localparam int DATA_WIDTH     = 130;
  localparam int LINK_VALID_BIT = 131;
  localparam int LINK_LAST_BIT  = 130;

  // Field order matches the wire: valid is the MSB, data the low bits.
  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } link_word_t;

endpackage

// File: rtl/pe_sync_fifo.sv
// rtl/pe_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy
module pe_sync_fifo #(
  parameter int WIDTH     = 131,
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   level
);

  localparam logic [ADDR_BITS:0] PTR_ONE = 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;
  logic               do_pop;
  logic               do_push;

  // Extra MSB on each pointer distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                 (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop in the same cycle frees the slot, so a push while full is still taken.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head entry is presented combinationally from storage.
  assign rdata = mem[rd_ptr[ADDR_BITS-1:0]];

  // Storage write; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr[ADDR_BITS-1:0]] <= wdata;
    end
  end

  // Pointer advance; natural binary wrap gives a seamless DEPTH-1 -> 0 transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/pe_link_rx_buffer.sv
// rtl/pe_link_rx_buffer.sv - receive elastic buffer for the free-running east link
module pe_link_rx_buffer
  import pe_link_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [LINK_WIDTH-1:0] in_from_west,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_BITS:0]    level,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [DATA_WIDTH:0] head;

  // Capture only flagged words while enabled; the link cannot be stalled.
  assign push = ap_start & in_from_west[LINK_VALID_BIT];
  assign pop  = out_valid & out_ready;

  pe_sync_fifo #(
    .WIDTH     (DATA_WIDTH + 1),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_from_west[LINK_LAST_BIT:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = ~empty;
  assign out_last  = head[DATA_WIDTH];
  assign out_data  = head[DATA_WIDTH-1:0];

  // Sticky drop flag: set only when a captured word finds no free slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Count packets as their last word leaves; wraps freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count <= '0;
    end else if (pop && out_last) begin
      pkt_count <= pkt_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pe_link_rx_buffer.sv
// tb/tb_pe_link_rx_buffer.sv - scoreboard bench for pe_link_rx_buffer
module tb_pe_link_rx_buffer;
  import pe_link_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  ap_start;
  logic [LINK_WIDTH-1:0] in_from_west;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            level;
  logic [15:0]           pkt_count;
  logic                  overflow;

  int          nchecks = 0;
  int          nerrors = 0;
  logic [130:0] exp_q[$];
  int          mlevel = 0;
  logic [15:0] mpkt = '0;
  logic        movf = 1'b0;
  logic [129:0] seq_data = '0;

  pe_link_rx_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .ap_start     (ap_start),
    .in_from_west (in_from_west),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .pkt_count    (pkt_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [LINK_WIDTH-1:0] lw(input logic v, input logic l, input logic [129:0] d);
    link_word_t w;
    w.valid = v;
    w.last  = l;
    w.data  = d;
    return w;
  endfunction

  task automatic chk(input string name, input logic [130:0] act, input logic [130:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model predicts the post-edge state.
  task automatic step(input logic v, input logic l, input logic [129:0] d, input logic rdy, input logic ap);
    logic mpop;
    logic mpush;
    in_from_west = lw(v, l, d);
    out_ready    = rdy;
    ap_start     = ap;
    mpop  = (mlevel > 0) && rdy;
    mpush = ap && v && ((mlevel < 8) || mpop);
    if (ap && v && !mpush) movf = 1'b1;
    if (mpop && exp_q.size() > 0 && exp_q[0][130]) mpkt = mpkt + 16'd1;
    if (mpush) exp_q.push_back({l, d});
    mlevel = mlevel + (mpush ? 1 : 0) - (mpop ? 1 : 0);
    @(posedge clk);
    #1;
    in_from_west = '0;
    out_ready    = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_level"},     131'(level),     131'(mlevel));
    chk({tag, "_valid"},     131'(out_valid), 131'(mlevel != 0));
    chk({tag, "_overflow"},  131'(overflow),  131'(movf));
    chk({tag, "_pkt_count"}, 131'(pkt_count), 131'(mpkt));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    mlevel = 0;
    mpkt   = '0;
    movf   = 1'b0;
    reset  = 1'b1;
  endtask

  // Monitor: compare every word the consumer accepts against the scoreboard head.
  initial begin
    logic [130:0] e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          nchecks++;
          nerrors++;
          $display("FAIL unexpected_pop: got %0h expected none", {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          chk("pop_word", {out_last, out_data}, e);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    ap_start     = 1'b0;
    out_ready    = 1'b0;
    in_from_west = '0;

    // 1. Reset held while valid words arrive.
    ap_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_from_west = lw(1'b1, 1'b1, 130'(i + 7));
      @(posedge clk);
      #1;
    end
    chk("rst_valid",    131'(out_valid), 131'(0));
    chk("rst_data",     131'(out_data),  131'(0));
    chk("rst_last",     131'(out_last),  131'(0));
    chk("rst_level",    131'(level),     131'(0));
    chk("rst_pkt",      131'(pkt_count), 131'(0));
    chk("rst_overflow", 131'(overflow),  131'(0));
    in_from_west = '0;
    reset = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("rel_valid", 131'(out_valid), 131'(0));

    // 2. Single word, one-cycle latency, then popped.
    step(1'b1, 1'b1, 130'h5A, 1'b0, 1'b1);
    chk("single_valid", 131'(out_valid), 131'(1));
    chk("single_data",  131'(out_data),  131'h5A);
    chk("single_last",  131'(out_last),  131'(1));
    chk("single_level", 131'(level),     131'(1));
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("single_pop_valid", 131'(out_valid), 131'(0));
    chk("single_pkt",       131'(pkt_count), 131'(1));

    // 3. Fill past capacity, then drain.
    do_reset();
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 130'(i), 1'b0, 1'b1);
    chk("fill_level",    131'(level),    131'(8));
    chk("fill_overflow", 131'(overflow), 131'(1));
    check_state("fill");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("drain_level", 131'(level), 131'(0));
    chk("drain_q",     131'(exp_q.size()), 131'(0));
    check_state("drain");

    // 4. Push and pop together while full.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 130'(16 + i), 1'b0, 1'b1);
    step(1'b1, 1'b1, 130'hAA, 1'b1, 1'b1);
    chk("full_pp_level",    131'(level),    131'(8));
    chk("full_pp_overflow", 131'(overflow), 131'(0));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("full_pp_q",   131'(exp_q.size()), 131'(0));
    chk("full_pp_pkt", 131'(pkt_count),    131'(1));

    // 5. Gated capture, streaming across pointer wrap, counter wrap.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 130'(i), 1'b0, 1'b0);
    chk("gate_level",    131'(level),    131'(0));
    chk("gate_overflow", 131'(overflow), 131'(0));
    for (int i = 0; i < 20; i++) step(1'b1, (i % 5) == 4, 130'(256 + i), 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("stream_pkt", 131'(pkt_count), 131'(4));
    check_state("stream");
    while (mpkt != 16'hFFFE) begin
      seq_data = seq_data + 130'd1;
      step(1'b1, 1'b1, seq_data, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("pkt_ffff", 131'(pkt_count), 131'h0FFFF);
    step(1'b1, 1'b1, 130'h3C, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("pkt_wrap", 131'(pkt_count), 131'(0));
    check_state("wrap");

    // 6. Asynchronous reset between edges.
    do_reset();
    step(1'b1, 1'b1, 130'h1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 130'(32 + i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("pre_async_level", 131'(level), 131'(5));
    check_state("pre_async");
    #2;
    reset = 1'b0;
    #1;
    chk("async_level",    131'(level),     131'(0));
    chk("async_valid",    131'(out_valid), 131'(0));
    chk("async_pkt",      131'(pkt_count), 131'(0));
    chk("async_overflow", 131'(overflow),  131'(0));
    exp_q.delete();
    mlevel = 0;
    mpkt   = '0;
    movf   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_state("post_async");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
